id_stage_pipelined: RTL and testbench
=====================================

Name: id_stage_pipelined

Overview:
Parametrised decode stage with an integrated ID/EX pipeline register and valid/ready handshakes on both sides. It reads the register file with write-back bypass, decodes control and immediates, detects load-use hazards against the instruction it last issued, inserts bubbles and honours flushes. It sits between the IF/ID register and the EX stage, replacing the purely combinational decode path.

Parameters:
XLEN, 64, datapath and PC width.
NREGS, 32, architectural register count; a power of two, at least 2.
RA_W, $clog2(NREGS), register address width (derived).
ALUOP_W, 3, width of the ALU operation code.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  IF/ID holds an instruction
in_ready  out  1  decode accepts the instruction this cycle
instr_in  in  32  instruction word
pc_in  in  XLEN  instruction PC
flush  in  1  kill the held output and the presented input (branch/jump redirect)
wb_en  in  1  write-back enable
wb_rd  in  RA_W  write-back destination
wb_data  in  XLEN  write-back data
out_valid  out  1  ID/EX register holds a valid instruction
out_ready  in  1  EX accepts the output
out_pc, out_rs1_data, out_rs2_data, out_imm  out  XLEN each  registered operands
out_rs1, out_rs2, out_rd  out  RA_W each  registered register addresses
out_aluop  out  ALUOP_W  registered ALU operation
out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write, out_beq, out_bne, out_jal, out_jalr  out  1 each  registered control bits

Behaviour:
- Clock is clk; reset is synchronous, active-high and sampled on the rising edge.
- Reset: all registers and every out_* signal clear to 0; out_valid = 0; in_ready = 0 while reset is high.
- Register file: NREGS x XLEN; register x0 reads 0 and ignores writes.
  - Writes commit at the clock edge when wb_en = 1 and wb_rd != 0.
  - Write-back bypass: a same-cycle read of wb_rd returns wb_data.
- Advance condition: adv = !out_valid || out_ready.
- Load-use hazard, combinational:
  - haz = out_valid && out_mem_read && out_rd != 0 && (out_rd == rs1 || out_rd == rs2).
  - The compare is on raw instruction fields, so it is conservative for U/J formats.
- in_ready = adv && !haz && !reset, or flush && !reset.
- Edge update, in priority order:
  1. reset
  2. flush: out_valid <= 0, and the presented input is consumed and discarded.
  3. adv && in_valid && !haz: load the decoded instruction into the ID/EX register; out_valid <= 1.
  4. adv && haz: bubble, out_valid <= 0, and the input is held. On the next cycle haz is 0 and the instruction is accepted.
  5. adv && !in_valid: out_valid <= 0.
  6. Otherwise hold all outputs stable (backpressure).
- Latency: one cycle from acceptance to out_valid. Throughput is 1 per cycle absent hazards. A load-use pair costs exactly one bubble.
- Control decode uses the existing ControlUnit encoding:
  - R: 0110011. I-ALU: 0010011. Load: 0000011. Store: 0100011.
  - Branch: 1100011, funct3 000 = BEQ, 001 = BNE.
  - JAL: 1101111. JALR: 1100111.
- Immediates are generated by ImmediateGenerator and sign-extended to XLEN.
- Unknown opcodes decode to all-zero controls, which makes them a NOP.
- Register-file writes proceed regardless of flush, stall or backpressure.
- When reset is asserted mid-stall, the pending instruction is dropped.

Optional Feature:
Macro: ID_ILLEGAL_DETECT_EN.
- Defined: adds output out_illegal (1 bit, registered with the other outputs, reset 0). It is set when:
  - the opcode is not in the decoded list, or
  - a branch funct3 is neither 000 nor 001.
  Illegal instructions still issue, with all-zero controls.
- Undefined: the port is absent, and unknown encodings silently become NOPs.

Decomposition:
- Package id_pkg holds:
  - opcode localparams
  - ALUop encodings
  - a packed struct ctrl_t for the nine control bits plus aluop
- Sub-module id_regfile (parametrised XLEN/NREGS, two read ports, one write port, bypass) is natural.
- ControlUnit and ImmediateGenerator are reused unchanged.

Test Plan:
1. Write x5 = 0x1234 via wb, then decode add x6,x5,x0 in the same cycle -> out_rs1_data = 0x1234 one cycle later (bypass).
2. ld x7,0(x1) followed by add x8,x7,x2 -> in_ready = 0 for one cycle, one bubble (out_valid = 0), and the add issues on the next cycle.
3. Hold out_ready = 0 for 3 cycles with in_valid = 1 -> all out_* stable, in_ready = 0, no instruction lost or duplicated.
4. Assert flush while out_valid = 1 and in_valid = 1 -> out_valid = 0 next cycle, and the flushed input never appears at the output.
5. wb_en = 1, wb_rd = 0, wb_data = 0xFFFF, then read x0 -> out_rs1_data = 0.
6. Opcode 0x7F with ID_ILLEGAL_DETECT_EN defined -> out_illegal = 1 and all controls 0. Without the macro -> NOP, with no out_illegal port.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions: opcodes, ALU op codes, the control bundle, and
// the control-unit / immediate-generator / illegal-check functions.
package id_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam int ALUOP_BITS = 3;
    localparam logic [ALUOP_BITS-1:0] ALU_ADD = 3'd0;
    localparam logic [ALUOP_BITS-1:0] ALU_SUB = 3'd1;
    localparam logic [ALUOP_BITS-1:0] ALU_R   = 3'd2;
    localparam logic [ALUOP_BITS-1:0] ALU_I   = 3'd3;

    typedef struct packed {
        logic                  mem_read;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  alu_src;
        logic                  reg_write;
        logic                  beq;
        logic                  bne;
        logic                  jal;
        logic                  jalr;
        logic [ALUOP_BITS-1:0] aluop;
    } ctrl_t;

    function automatic ctrl_t control_unit(input logic [6:0] opcode, input logic [2:0] funct3);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_R:    begin c.reg_write = 1'b1; c.aluop = ALU_R; end
            OP_IALU: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.aluop = ALU_I; end
            OP_LOAD: begin
                c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.alu_src = 1'b1;
                c.reg_write = 1'b1; c.aluop = ALU_ADD;
            end
            OP_STORE: begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.aluop = ALU_ADD; end
            // Branches with an unsupported funct3 fall through as a NOP.
            OP_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    c.beq = 1'b1; c.aluop = ALU_SUB;
                end else if (funct3 == F3_BNE) begin
                    c.bne = 1'b1; c.aluop = ALU_SUB;
                end
            end
            OP_JAL:  begin c.jal = 1'b1; c.reg_write = 1'b1; c.aluop = ALU_ADD; end
            OP_JALR: begin
                c.jalr = 1'b1; c.reg_write = 1'b1; c.alu_src = 1'b1; c.aluop = ALU_ADD;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] imm_gen(input logic [31:0] instr);
        logic [31:0] imm;
        imm = '0;
        case (instr[6:0])
            OP_IALU, OP_LOAD, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_JAL:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:   imm = '0;
        endcase
        return imm;
    endfunction

    function automatic logic is_illegal(input logic [6:0] opcode, input logic [2:0] funct3);
        logic ill;
        case (opcode)
            OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_JAL, OP_JALR: ill = 1'b0;
            OP_BRANCH: ill = (funct3 != F3_BEQ) && (funct3 != F3_BNE);
            default:   ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file, two async read ports with write-back bypass, one write port.
// x0 reads zero and is never written; writes commit on the rising edge.
module id_regfile #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int RA_W  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_en_i,
    input  logic [RA_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic [RA_W-1:0] rd_addr1_i,
    input  logic [RA_W-1:0] rd_addr2_i,
    output logic [XLEN-1:0] rd_data1_o,
    output logic [XLEN-1:0] rd_data2_o
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_act;

    assign wr_act = wb_en_i && (wb_rd_i != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_act) begin
            regs_q[wb_rd_i] <= wb_data_i;
        end
    end

    always_comb begin
        rd_data1_o = '0;
        rd_data2_o = '0;
        if (rd_addr1_i != '0) rd_data1_o = (wr_act && wb_rd_i == rd_addr1_i) ? wb_data_i : regs_q[rd_addr1_i];
        if (rd_addr2_i != '0) rd_data2_o = (wr_act && wb_rd_i == rd_addr2_i) ? wb_data_i : regs_q[rd_addr2_i];
    end

endmodule

// File: rtl/id_stage_pipelined.sv
// Decode stage with ID/EX register: 1-cycle latency, stalls on EX backpressure, one bubble per load-use.
// Optional out_illegal port when ID_ILLEGAL_DETECT_EN is defined.
module id_stage_pipelined
    import id_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int NREGS   = 32,
    parameter int RA_W    = $clog2(NREGS),
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr_in,
    input  logic [XLEN-1:0]    pc_in,
    input  logic               flush,
    input  logic               wb_en,
    input  logic [RA_W-1:0]    wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_rs1_data,
    output logic [XLEN-1:0]    out_rs2_data,
    output logic [XLEN-1:0]    out_imm,
    output logic [RA_W-1:0]    out_rs1,
    output logic [RA_W-1:0]    out_rs2,
    output logic [RA_W-1:0]    out_rd,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic               out_mem_read,
    output logic               out_mem_to_reg,
    output logic               out_mem_write,
    output logic               out_alu_src,
    output logic               out_reg_write,
    output logic               out_beq,
    output logic               out_bne,
    output logic               out_jal,
    output logic               out_jalr
`ifdef ID_ILLEGAL_DETECT_EN
    ,
    output logic               out_illegal
`endif
);

    logic [RA_W-1:0] rs1, rs2, rd;
    logic [XLEN-1:0] rs1_data_d, rs2_data_d, imm_d;
    ctrl_t           ctrl_d, ctrl_q;
    logic            adv, haz, load, valid_d;

    logic            out_valid_q;
    logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [RA_W-1:0] rs1_q, rs2_q, rd_q;

    assign rs1    = instr_in[15 +: RA_W];
    assign rs2    = instr_in[20 +: RA_W];
    assign rd     = instr_in[7 +: RA_W];
    assign ctrl_d = control_unit(instr_in[6:0], instr_in[14:12]);
    assign imm_d  = XLEN'($signed(imm_gen(instr_in)));

    id_regfile #(.XLEN(XLEN), .NREGS(NREGS), .RA_W(RA_W)) u_regfile (
        .clk        (clk),
        .reset      (reset),
        .wb_en_i    (wb_en),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data),
        .rd_addr1_i (rs1),
        .rd_addr2_i (rs2),
        .rd_data1_o (rs1_data_d),
        .rd_data2_o (rs2_data_d)
    );

    // Hazard uses raw rs fields, so U/J formats may stall needlessly.
    always_comb begin
        adv      = !out_valid_q || out_ready;
        haz      = out_valid_q && ctrl_q.mem_read && (rd_q != '0) && ((rd_q == rs1) || (rd_q == rs2));
        in_ready = !reset && ((adv && !haz) || flush);
        load     = !flush && adv && in_valid && !haz;
        valid_d  = out_valid_q;
        if (flush)     valid_d = 1'b0;
        else if (load) valid_d = 1'b1;
        else if (adv)  valid_d = 1'b0;
    end

`ifdef ID_ILLEGAL_DETECT_EN
    logic illegal_q;
    always_ff @(posedge clk) begin
        if (reset)     illegal_q <= 1'b0;
        else if (load) illegal_q <= is_illegal(instr_in[6:0], instr_in[14:12]);
    end
    assign out_illegal = illegal_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
        end else begin
            out_valid_q <= valid_d;
            if (load) begin
                ctrl_q     <= ctrl_d;
                pc_q       <= pc_in;
                rs1_data_q <= rs1_data_d;
                rs2_data_q <= rs2_data_d;
                imm_q      <= imm_d;
                rs1_q      <= rs1;
                rs2_q      <= rs2;
                rd_q       <= rd;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pc         = pc_q;
    assign out_rs1_data   = rs1_data_q;
    assign out_rs2_data   = rs2_data_q;
    assign out_imm        = imm_q;
    assign out_rs1        = rs1_q;
    assign out_rs2        = rs2_q;
    assign out_rd         = rd_q;
    assign out_aluop      = ALUOP_W'(ctrl_q.aluop);
    assign out_mem_read   = ctrl_q.mem_read;
    assign out_mem_to_reg = ctrl_q.mem_to_reg;
    assign out_mem_write  = ctrl_q.mem_write;
    assign out_alu_src    = ctrl_q.alu_src;
    assign out_reg_write  = ctrl_q.reg_write;
    assign out_beq        = ctrl_q.beq;
    assign out_bne        = ctrl_q.bne;
    assign out_jal        = ctrl_q.jal;
    assign out_jalr       = ctrl_q.jalr;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: directed plan items plus randomized traffic
// compared every cycle against a transaction-level model of the stage.
module tb_id_stage_pipelined;

    localparam int XLEN = 64, NREGS = 32, RA_W = 5, ALUOP_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
    logic [31:0]        instr_in;
    logic [XLEN-1:0]    pc_in, wb_data;
    logic [RA_W-1:0]    wb_rd;
    logic [XLEN-1:0]    out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [RA_W-1:0]    out_rs1, out_rs2, out_rd;
    logic [ALUOP_W-1:0] out_aluop;
    logic out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write;
    logic out_beq, out_bne, out_jal, out_jalr;
`ifdef ID_ILLEGAL_DETECT_EN
    logic out_illegal;
`endif

    id_stage_pipelined #(.XLEN(XLEN), .NREGS(NREGS), .RA_W(RA_W), .ALUOP_W(ALUOP_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .pc_in(pc_in), .flush(flush),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_aluop(out_aluop),
        .out_mem_read(out_mem_read), .out_mem_to_reg(out_mem_to_reg), .out_mem_write(out_mem_write),
        .out_alu_src(out_alu_src), .out_reg_write(out_reg_write), .out_beq(out_beq),
        .out_bne(out_bne), .out_jal(out_jal), .out_jalr(out_jalr)
`ifdef ID_ILLEGAL_DETECT_EN
        , .out_illegal(out_illegal)
`endif
    );

    typedef struct {
        logic [63:0] pc, r1d, r2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [11:0] ctl;   // {mr, m2r, mw, alu_src, rw, beq, bne, jal, jalr, aluop[2:0]}
        logic        ill;
    } exp_t;

    exp_t        held;
    logic        hv = 1'b0;
    logic [63:0] rf [NREGS];
    int          checks = 0;
    int          errs = 0;
    logic        smp_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_ctl(input logic [31:0] i);
        case (i[6:0])
            7'h33: return 12'b000010000_010;
            7'h13: return 12'b000110000_011;
            7'h03: return 12'b110110000_000;
            7'h23: return 12'b001100000_000;
            7'h63: return (i[14:12] == 3'd0) ? 12'b000001000_001 :
                          (i[14:12] == 3'd1) ? 12'b000000100_001 : 12'd0;
            7'h6F: return 12'b000010010_000;
            7'h67: return 12'b000110001_000;
            default: return 12'd0;
        endcase
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] i);
        longint v;
        case (i[6:0])
            7'h13, 7'h03, 7'h67: v = longint'(i[31:20]) - (i[31] ? 64'sd4096 : 64'sd0);
            7'h23: v = longint'({i[31:25], i[11:7]}) - (i[31] ? 64'sd4096 : 64'sd0);
            7'h63: v = 2048 * longint'(i[7]) + 32 * longint'(i[30:25]) + 2 * longint'(i[11:8])
                       - (i[31] ? 64'sd4096 : 64'sd0);
            7'h6F: v = 4096 * longint'(i[19:12]) + 2048 * longint'(i[20]) + 2 * longint'(i[30:21])
                       - (i[31] ? 64'sd1048576 : 64'sd0);
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    function automatic logic ref_ill(input logic [31:0] i);
        case (i[6:0])
            7'h33, 7'h13, 7'h03, 7'h23, 7'h6F, 7'h67: return 1'b0;
            7'h63: return i[14:12] > 3'd1;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [63:0] ref_read(input logic [4:0] r);
        if (r == 5'd0) return 64'd0;
        if (wb_en && wb_rd == r) return wb_data;
        return rf[r];
    endfunction

    function automatic logic [11:0] dut_ctl();
        return {out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write,
                out_beq, out_bne, out_jal, out_jalr, out_aluop};
    endfunction

    // One cycle: check DUT against the model mid-cycle, advance the model, land after the edge.
    task automatic step();
        logic [4:0] r1, r2;
        logic       adv, haz, exp_rdy;
        exp_t       n;
        @(negedge clk); #1;
        r1      = instr_in[19:15];
        r2      = instr_in[24:20];
        adv     = !hv || out_ready;
        haz     = hv && held.ctl[11] && held.rd != 5'd0 && (held.rd == r1 || held.rd == r2);
        exp_rdy = !reset && ((adv && !haz) || flush);
        smp_ready = in_ready;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(hv));
        if (hv) begin
            chk("out_pc", out_pc, held.pc);
            chk("out_rs1_data", out_rs1_data, held.r1d);
            chk("out_rs2_data", out_rs2_data, held.r2d);
            chk("out_imm", out_imm, held.imm);
            chk("out_regs", 64'({out_rs1, out_rs2, out_rd}), 64'({held.rs1, held.rs2, held.rd}));
            chk("out_ctrl", 64'(dut_ctl()), 64'(held.ctl));
`ifdef ID_ILLEGAL_DETECT_EN
            chk("out_illegal", 64'(out_illegal), 64'(held.ill));
`endif
        end
        if (reset) begin
            hv = 1'b0;
            for (int k = 0; k < NREGS; k++) rf[k] = 64'd0;
        end else begin
            n.pc = pc_in; n.r1d = ref_read(r1); n.r2d = ref_read(r2);
            n.imm = ref_imm(instr_in); n.rs1 = r1; n.rs2 = r2; n.rd = instr_in[11:7];
            n.ctl = ref_ctl(instr_in); n.ill = ref_ill(instr_in);
            if (flush) hv = 1'b0;
            else if (adv && in_valid && !haz) begin hv = 1'b1; held = n; end
            else if (adv) hv = 1'b0;
            if (wb_en && wb_rd != 5'd0) rf[wb_rd] = wb_data;
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 10))
            0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2, 3: w[6:0] = 7'h03;
            4: w[6:0] = 7'h23;  5, 6: w[6:0] = 7'h63; 7: w[6:0] = 7'h6F;
            8: w[6:0] = 7'h67;  9: w[6:0] = 7'h7F;  default: w[6:0] = 7'h37;
        endcase
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        w[11:7]  = 5'($urandom_range(0, 7));
        return w;
    endfunction

    task automatic drive(input logic iv, input logic [31:0] ins, input logic fl,
                         input logic we, input int wrd, input logic [63:0] wd, input logic ordy);
        in_valid = iv; instr_in = ins; flush = fl; out_ready = ordy;
        wb_en = we; wb_rd = 5'(wrd); wb_data = wd; pc_in = {$urandom, $urandom};
    endtask

    initial begin
        for (int k = 0; k < NREGS; k++) rf[k] = 64'd0;
        reset = 1'b1;
        drive(1'b1, enc_r(3, 1, 2), 1'b0, 1'b0, 0, 64'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        repeat (2) step();
        chk("rst_ready", 64'(smp_ready), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_ctrl", 64'({dut_ctl(), out_rd}), 64'd0);

        // write to x0 with same-cycle read of x0
        reset = 1'b0;
        drive(1'b1, enc_r(9, 0, 0), 1'b0, 1'b1, 0, 64'hFFFF, 1'b1);
        step();
        chk("x0_read", out_rs1_data, 64'd0);
        // bypass of x5
        drive(1'b1, enc_r(6, 5, 0), 1'b0, 1'b1, 5, 64'h1234, 1'b1);
        step();
        chk("bypass_rs1", out_rs1_data, 64'h1234);
        chk("bypass_ctrl", 64'({out_rd, out_reg_write, out_aluop}), 64'({5'd6, 1'b1, 3'd2}));

        // ld x7,0(x1) then add x8,x7,x2
        drive(1'b1, {12'd0, 5'd1, 3'b011, 5'd7, 7'h03}, 1'b0, 1'b0, 0, 64'd0, 1'b1);
        step();
        chk("ld_issue", 64'({out_valid, out_mem_read}), 64'b11);
        drive(1'b1, enc_r(8, 7, 2), 1'b0, 1'b0, 0, 64'd0, 1'b1);
        step();
        chk("lu_ready", 64'(smp_ready), 64'd0);
        chk("lu_bubble", 64'(out_valid), 64'd0);
        step();
        chk("lu_accept", 64'(smp_ready), 64'd1);
        chk("lu_issue", 64'({out_valid, out_rd}), 64'({1'b1, 5'd8}));

        // backpressure for three cycles
        drive(1'b1, enc_r(10, 1, 2), 1'b0, 1'b0, 0, 64'd0, 1'b1);
        step();
        drive(1'b1, enc_r(11, 3, 4), 1'b0, 1'b0, 0, 64'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_ready", 64'(smp_ready), 64'd0);
            chk("bp_hold", 64'({out_valid, out_rd}), 64'({1'b1, 5'd10}));
        end
        out_ready = 1'b1;
        step();
        chk("bp_next", 64'({out_valid, out_rd}), 64'({1'b1, 5'd11}));

        // flush with output held and input presented
        drive(1'b1, enc_r(12, 1, 1), 1'b1, 1'b0, 0, 64'd0, 1'b0);
        step();
        chk("fl_ready", 64'(smp_ready), 64'd1);
        chk("fl_valid", 64'(out_valid), 64'd0);
        drive(1'b0, enc_r(12, 1, 1), 1'b0, 1'b0, 0, 64'd0, 1'b1);
        step();
        chk("fl_gone", 64'(out_valid), 64'd0);

        // unknown opcode 0x7F
        drive(1'b1, 32'h0000_057F, 1'b0, 1'b0, 0, 64'd0, 1'b1);
        step();
        chk("unk_nop", 64'({out_valid, dut_ctl()}), 64'({1'b1, 12'd0}));
`ifdef ID_ILLEGAL_DETECT_EN
        chk("unk_illegal", 64'(out_illegal), 64'd1);
`endif

        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 15) == 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 7), {$urandom, $urandom},
                  $urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
